// File: rtl/fetch_pkg.sv
// rtl/fetch_pkg.sv - shared types and default widths for the window fetch path
package fetch_pkg;

   typedef enum logic [1:0] {IDLE, FETCH, DRAIN, DONE} fetch_state_t;

   localparam int DEF_ADDR_WIDTH  = 8;
   localparam int DEF_DATA_WIDTH  = 8;
   localparam int DEF_DATA_LENGTH = 9;

endpackage

// File: rtl/window_fetch.sv
// rtl/window_fetch.sv - reads a kernel window of addresses from activation SRAM
// one element per cycle and presents the packed window with valid/ready.
module window_fetch
   import fetch_pkg::*;
#(
   parameter int ADDR_WIDTH  = DEF_ADDR_WIDTH,
   parameter int DATA_WIDTH  = DEF_DATA_WIDTH,
   parameter int DATA_LENGTH = DEF_DATA_LENGTH,
   parameter int CNT_WIDTH   = $clog2(DATA_LENGTH + 1)
) (
   input  logic                                    i_clk,
   input  logic                                    i_nrst,
   input  logic                                    i_reg_clear,
   input  logic                                    i_addr_valid,
   input  logic [0:DATA_LENGTH-1][ADDR_WIDTH-1:0]  i_addr,
   output logic                                    o_addr_ready,
   output logic                                    o_mem_re,
   output logic [ADDR_WIDTH-1:0]                   o_mem_addr,
   input  logic [DATA_WIDTH-1:0]                   i_mem_data,
   output logic                                    o_data_valid,
   output logic [0:DATA_LENGTH-1][DATA_WIDTH-1:0]  o_data,
   input  logic                                    i_data_ready
);

   fetch_state_t                            r_state;
   fetch_state_t                            w_state_nxt;
   logic [0:DATA_LENGTH-1][ADDR_WIDTH-1:0]  r_addr_q;
   logic [0:DATA_LENGTH-1][DATA_WIDTH-1:0]  r_data;
   logic [CNT_WIDTH-1:0]                    r_idx;
   logic [CNT_WIDTH-1:0]                    r_mem_idx;
   logic [CNT_WIDTH-1:0]                    r_idx_d;
   logic                                    r_mem_re;
   logic                                    r_re_d;
   logic [ADDR_WIDTH-1:0]                   r_mem_addr;
   logic                                    w_last_issued;

   assign w_last_issued = (r_idx == CNT_WIDTH'(DATA_LENGTH));

   always_ff @(posedge i_clk or negedge i_nrst) begin
      if (!i_nrst) r_state <= IDLE;
      else         r_state <= w_state_nxt;
   end

   always_comb begin
      w_state_nxt = r_state;
      if (i_reg_clear) begin
         w_state_nxt = IDLE;
      end else begin
         case (r_state)
            IDLE:    if (i_addr_valid) w_state_nxt = FETCH;
            FETCH:   if (w_last_issued) w_state_nxt = DRAIN;
            DRAIN:   w_state_nxt = DONE;
            DONE:    if (i_data_ready) w_state_nxt = IDLE;
            default: w_state_nxt = IDLE;
         endcase
      end
   end

   always_comb begin
      o_addr_ready = (r_state == IDLE);
      o_data_valid = (r_state == DONE);
   end

   // The first read is launched on the accept edge so reads stay registered
   // yet start the cycle right after the handshake; r_mem_idx tags each read.
   always_ff @(posedge i_clk or negedge i_nrst) begin
      if (!i_nrst) begin
         r_addr_q   <= '0;
         r_data     <= '0;
         r_idx      <= '0;
         r_mem_idx  <= '0;
         r_idx_d    <= '0;
         r_mem_re   <= 1'b0;
         r_re_d     <= 1'b0;
         r_mem_addr <= '0;
      end else if (i_reg_clear) begin
         r_data     <= '0;
         r_idx      <= '0;
         r_mem_idx  <= '0;
         r_idx_d    <= '0;
         r_mem_re   <= 1'b0;
         r_re_d     <= 1'b0;
         r_mem_addr <= '0;
      end else begin
         r_re_d  <= r_mem_re;
         r_idx_d <= r_mem_idx;
         if (r_re_d) r_data[r_idx_d] <= i_mem_data;
         case (r_state)
            IDLE: begin
               if (i_addr_valid) begin
                  r_addr_q   <= i_addr;
                  r_mem_re   <= 1'b1;
                  r_mem_addr <= i_addr[0];
                  r_mem_idx  <= '0;
                  r_idx      <= CNT_WIDTH'(1);
               end
            end
            FETCH: begin
               if (w_last_issued) begin
                  r_mem_re <= 1'b0;
               end else begin
                  r_mem_addr <= r_addr_q[r_idx];
                  r_mem_idx  <= r_idx;
                  r_idx      <= r_idx + CNT_WIDTH'(1);
               end
            end
            default: r_mem_re <= 1'b0;
         endcase
      end
   end

   assign o_mem_re   = r_mem_re;
   assign o_mem_addr = r_mem_addr;
   assign o_data     = r_data;

endmodule

// File: tb/tb_window_fetch.sv
// tb/tb_window_fetch.sv - directed scoreboard bench for window_fetch with an SRAM model
module tb_window_fetch;
   import fetch_pkg::*;

   localparam int AW = DEF_ADDR_WIDTH;
   localparam int DW = DEF_DATA_WIDTH;
   localparam int DL = DEF_DATA_LENGTH;

   typedef logic [0:DL-1][AW-1:0] avec_t;
   typedef logic [0:DL-1][DW-1:0] win_t;

   logic          i_clk;
   logic          i_nrst;
   logic          i_reg_clear;
   logic          i_addr_valid;
   avec_t         i_addr;
   logic          o_addr_ready;
   logic          o_mem_re;
   logic [AW-1:0] o_mem_addr;
   logic [DW-1:0] i_mem_data;
   logic          o_data_valid;
   win_t          o_data;
   logic          i_data_ready;

   logic [DW-1:0] mem [256];
   logic [AW-1:0] exp_addr_q[$];
   win_t          exp_win_q[$];
   int            checks = 0;
   int            failures = 0;

   window_fetch dut (
      .i_clk(i_clk), .i_nrst(i_nrst), .i_reg_clear(i_reg_clear),
      .i_addr_valid(i_addr_valid), .i_addr(i_addr), .o_addr_ready(o_addr_ready),
      .o_mem_re(o_mem_re), .o_mem_addr(o_mem_addr), .i_mem_data(i_mem_data),
      .o_data_valid(o_data_valid), .o_data(o_data), .i_data_ready(i_data_ready)
   );

   initial begin
      i_clk = 1'b0;
      forever #5 i_clk = ~i_clk;
   end

   always @(posedge i_clk) if (o_mem_re) i_mem_data <= mem[o_mem_addr];

   task automatic chk(input string tag, input logic [127:0] obs, input logic [127:0] exp);
      checks++;
      assert (obs === exp) else begin
         failures++;
         $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   function automatic win_t model(input avec_t a);
      win_t w;
      for (int k = 0; k < DL; k++) w[k] = mem[a[k]];
      return w;
   endfunction

   // Address and window scoreboards
   always @(negedge i_clk) begin
      if (i_nrst && o_mem_re) begin
         if (exp_addr_q.size() == 0) chk("addr_unexpected", 1, 0);
         else chk("mem_addr", o_mem_addr, exp_addr_q.pop_front());
      end
      if (i_nrst && o_data_valid && i_data_ready) begin
         if (exp_win_q.size() == 0) chk("win_unexpected", 1, 0);
         else chk("window", o_data, exp_win_q.pop_front());
      end
   end

   task automatic push_exp(input avec_t v, input bit with_win);
      for (int k = 0; k < DL; k++) exp_addr_q.push_back(v[k]);
      if (with_win) exp_win_q.push_back(model(v));
   endtask

   // Called just after a posedge; returns just after the accept edge
   task automatic send(input avec_t v, input bit with_win);
      i_addr = v;
      i_addr_valid = 1'b1;
      push_exp(v, with_win);
      @(posedge i_clk); #1;
      i_addr_valid = 1'b0;
   endtask

   task automatic wait_valid(input string tag);
      int n = 0;
      do begin
         @(negedge i_clk);
         n++;
      end while (!o_data_valid && n < 40);
      chk(tag, n, 11);
   endtask

   avec_t v1, v2, vdup;
   win_t  held;
   int    n;

   initial begin
      for (int a = 0; a < 256; a++) mem[a] = 8'(a + 8'h40);
      v1   = {8'd0, 8'd1, 8'd2, 8'd8, 8'd9, 8'd10, 8'd16, 8'd17, 8'd18};
      v2   = {8'd200, 8'd3, 8'd3, 8'd77, 8'd255, 8'd128, 8'd5, 8'd64, 8'd31};
      vdup = {DL{8'h3F}};
      i_nrst = 1'b0; i_reg_clear = 1'b0; i_addr_valid = 1'b0;
      i_addr = '0; i_data_ready = 1'b1;

      // Reset state
      @(negedge i_clk);
      chk("rst_addr_ready", o_addr_ready, 1);
      chk("rst_mem_re", o_mem_re, 0);
      chk("rst_mem_addr", o_mem_addr, 0);
      chk("rst_data_valid", o_data_valid, 0);
      chk("rst_data", o_data, 0);
      @(posedge i_clk); #1;
      i_nrst = 1'b1;
      @(posedge i_clk); #1;

      // Single window, one-cycle valid pulse
      send(v1, 1'b1);
      wait_valid("t1_latency");
      chk("t1_data", o_data, {8'h40, 8'h41, 8'h42, 8'h48, 8'h49, 8'h4A, 8'h50, 8'h51, 8'h52});
      @(negedge i_clk);
      chk("t1_pulse_drop", o_data_valid, 0);
      chk("t1_idle_ready", o_addr_ready, 1);

      // Back-pressure in DONE
      @(posedge i_clk); #1;
      i_data_ready = 1'b0;
      send(v1, 1'b1);
      wait_valid("t2_latency");
      held = o_data;
      for (int c = 0; c < 5; c++) begin
         @(negedge i_clk);
         chk("t2_valid_hold", o_data_valid, 1);
         chk("t2_data_hold", o_data, held);
         chk("t2_no_read", o_mem_re, 0);
         chk("t2_not_ready", o_addr_ready, 0);
      end
      @(posedge i_clk); #1;
      i_data_ready = 1'b1;
      @(negedge i_clk);
      @(negedge i_clk);
      chk("t2_idle_after", o_addr_ready, 1);
      chk("t2_valid_drop", o_data_valid, 0);

      // Back-to-back with valid held high; second vector waits in i_addr
      @(posedge i_clk); #1;
      i_addr = v1; i_addr_valid = 1'b1;
      push_exp(v1, 1'b1);
      push_exp(v2, 1'b1);
      @(posedge i_clk); #1;
      i_addr = v2;
      n = 0;
      do begin
         @(negedge i_clk);
         n++;
      end while (!o_addr_ready && n < 40);
      chk("t3_accept_gap", n, 12);
      @(posedge i_clk); #1;
      i_addr_valid = 1'b0;
      wait_valid("t3_latency2");
      @(negedge i_clk);
      chk("t3_done", o_data_valid, 0);

      // Clear mid-fetch, then a clean window
      @(posedge i_clk); #1;
      send(v2, 1'b0);
      repeat (4) @(posedge i_clk);
      #1 i_reg_clear = 1'b1;
      @(negedge i_clk);
      @(negedge i_clk);
      chk("t4_mem_re", o_mem_re, 0);
      chk("t4_data_zero", o_data, 0);
      chk("t4_addr_ready", o_addr_ready, 1);
      chk("t4_valid", o_data_valid, 0);
      chk("t4_reads_before_clear", exp_addr_q.size(), DL - 5);
      exp_addr_q.delete();
      #1 i_reg_clear = 1'b0;
      @(posedge i_clk); #1;
      send(v1, 1'b1);
      wait_valid("t4_latency");

      // Clear and valid in the same cycle: vector not accepted
      @(posedge i_clk); #1;
      i_addr = v2; i_addr_valid = 1'b1; i_reg_clear = 1'b1;
      @(posedge i_clk); #1;
      i_addr_valid = 1'b0; i_reg_clear = 1'b0;
      @(negedge i_clk);
      chk("t5_clear_wins_re", o_mem_re, 0);
      chk("t5_clear_wins_ready", o_addr_ready, 1);

      // Asynchronous reset while DONE waits
      @(posedge i_clk); #1;
      i_data_ready = 1'b0;
      send(v2, 1'b0);
      wait_valid("t6_latency");
      #2 i_nrst = 1'b0;
      #1;
      chk("t6_async_valid", o_data_valid, 0);
      chk("t6_async_data", o_data, 0);
      chk("t6_async_ready", o_addr_ready, 1);
      @(posedge i_clk); #1;
      i_nrst = 1'b1; i_data_ready = 1'b1;
      @(posedge i_clk); #1;

      // Duplicate addresses read separately
      mem[8'h3F] = 8'hA5;
      send(vdup, 1'b1);
      wait_valid("t7_latency");
      chk("t7_data", o_data, {DL{8'hA5}});
      @(negedge i_clk);
      @(negedge i_clk);

      chk("addr_q_empty", exp_addr_q.size(), 0);
      chk("win_q_empty", exp_win_q.size(), 0);
      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule

// File: doc/window_fetch.md
Name: window_fetch

Overview:
- Consumer/responder for a packed kernel-window address vector from the router address stage, plus its valid strobe.
- Accepts one vector of DATA_LENGTH addresses and reads each element from a single-port, 1-cycle-latency activation SRAM, one per cycle.
- Assembles the returned words into one packed window and presents it to the PE-array feed with a valid/ready handshake.
- Sits in the flash router, between the address stage and the systolic-array input staging.

Parameters:
- ADDR_WIDTH, 8, width of each address element and of o_mem_addr.
- DATA_WIDTH, 8, width of each activation word.
- DATA_LENGTH, 9, elements per window (KERNEL_SIZE squared).
- CNT_WIDTH, $clog2(DATA_LENGTH+1), element index counter width.

Ports:
- i_clk  in  1  clock; all state updates on rising edge.
- i_nrst  in  1  reset, asynchronous, active-low.
- i_reg_clear  in  1  synchronous clear; highest priority after reset.
- i_addr_valid  in  1  address vector valid.
- i_addr  in  [0:DATA_LENGTH-1][ADDR_WIDTH-1:0]  window addresses; element 0 is top-left.
- o_addr_ready  out  1  block can accept a vector.
- o_mem_re  out  1  SRAM read enable.
- o_mem_addr  out  ADDR_WIDTH  SRAM read address.
- i_mem_data  in  DATA_WIDTH  SRAM read data; valid the cycle after o_mem_re.
- o_data_valid  out  1  packed window valid.
- o_data  out  [0:DATA_LENGTH-1][DATA_WIDTH-1:0]  packed window; element k read from i_addr[k].
- i_data_ready  in  1  downstream accepts window.

Behaviour:
- Reset values (i_nrst low):
  - state = IDLE; o_addr_ready = 1.
  - o_mem_re = 0, o_mem_addr = 0.
  - o_data_valid = 0, o_data = all zeros.
  - Counters and captured addresses = 0.
- States: IDLE, FETCH, DRAIN, DONE.
- IDLE:
  - o_addr_ready = 1.
  - On i_addr_valid && o_addr_ready: latch i_addr into a local vector, idx = 0, go to FETCH.
- FETCH:
  - Each cycle drive o_mem_re = 1 and o_mem_addr = addr_q[idx]; idx increments.
  - After idx = DATA_LENGTH-1 is issued, go to DRAIN.
- Capture pipeline:
  - re_d and idx_d are o_mem_re and idx delayed one cycle.
  - When re_d = 1, o_data[idx_d] <= i_mem_data.
- DRAIN:
  - o_mem_re = 0; captures the last word; goes to DONE.
- DONE:
  - o_data_valid = 1; o_data is held stable.
  - On i_data_ready, go to IDLE; o_data_valid drops the next cycle.
- o_addr_ready is 0 in FETCH, DRAIN and DONE. No new vector is accepted until the window is consumed, so there is no overlap.
- Latency with handshake accepted at edge T:
  - reads are issued in cycles T+1..T+DATA_LENGTH;
  - o_data_valid is high from cycle T+DATA_LENGTH+2 (T+11 at defaults).
- Throughput: one window per DATA_LENGTH+3 cycles when i_data_ready is held high.
- Register and width rules:
  - o_mem_addr and o_mem_re are registered outputs.
  - Addresses pass through unmodified; no arithmetic, no wrap handling.
  - Duplicate addresses are each read separately.
- i_addr and i_addr_valid changing while not in IDLE: ignored.
- i_reg_clear:
  - forces IDLE, zeroes o_data, o_data_valid, o_mem_re, o_mem_addr, re_d and idx;
  - takes effect regardless of state, including mid-FETCH or while DONE is waiting.
- i_reg_clear with i_addr_valid in the same cycle: the clear wins and the vector is not accepted.
- Reset asserted mid-operation: immediate return to the reset values; the partial window is discarded.
- o_data after a handshake: keeps its last value until overwritten by the next capture or cleared.
- Back-pressure: i_data_ready low in DONE holds the state indefinitely. No SRAM reads are issued while holding.

Decomposition:
- Shared package fetch_pkg:
  - fetch_state_t enum {IDLE, FETCH, DRAIN, DONE};
  - default width constants for ADDR_WIDTH, DATA_WIDTH and DATA_LENGTH, shared with the address stage so the vector types match.
- No sub-module: the FSM, counter and capture register fit in a single module.
- The bench supplies an SRAM behavioural model (1-cycle read latency).

Test Plan:
- Single window: preload mem[a] = a+0x40; send i_addr = {0,1,2,8,9,10,16,17,18} with valid at T, ready held high -> o_mem_addr sequence 0,1,2,8,9,10,16,17,18 in T+1..T+9; o_data_valid at T+11 with o_data = {0x40,0x41,0x42,0x48,0x49,0x4A,0x50,0x51,0x52}; one-cycle pulse.
- Back-pressure: same window, i_data_ready low for 5 cycles in DONE -> o_data_valid and o_data stable, o_mem_re = 0, o_addr_ready = 0 throughout; on ready, IDLE next cycle.
- Back-to-back: valid held high with two vectors, ready high -> second accept exactly 12 cycles after first; both windows correct; no read overlap.
- Clear mid-fetch: i_reg_clear asserted at T+5 -> next cycle o_mem_re = 0, o_data all zeros, o_addr_ready = 1; a following window reads correctly.
- Async reset in DONE: i_nrst low between edges -> o_data_valid = 0 and o_data = 0 immediately, without waiting for a clock edge.
- Duplicate addresses: i_addr all = 0x3F, mem[0x3F] = 0xA5 -> 9 reads issued; o_data all 0xA5.
